uart_rx_frame: RTL and testbench

//  Receive half of the UART link: recovers frames produced by the UART transmitter
//  (start, DATA_WIDTH data bits LSB first, optional parity, one stop bit) from serial RX_IN.

---
 rtl/uart_rx_frame.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_frame.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: receive half of the UART link.
//
// Recovers frames of the form start, DATA_WIDTH data bits LSB first, optional
// parity, one stop bit from the serial line. Each bit is oversampled PRESCALE
// times. Three samples around mid-bit are majority-voted, and the result is
// taken two cycles after the centre sample. A good frame updates P_DATA and
// pulses DATA_VALID. A bad frame pulses PAR_ERR and/or STP_ERR and leaves
// P_DATA unchanged.
//
// Ports
//   CLK        in   oversampling clock (PRESCALE x bit rate)
//   RST        in   synchronous reset, active low
//   RX_IN      in   serial line, idle high, asynchronous to CLK
//   PAR_EN     in   1: a parity bit follows the data bits
//   PAR_TYP    in   0: even parity, 1: odd parity
//   PRESCALE   in   CLK cycles per bit (8, 16 or 32)
//   P_DATA     out  last word received without error
//   DATA_VALID out  one-cycle pulse, P_DATA updated
//   PAR_ERR    out  one-cycle pulse, parity mismatch on the frame just ended
//   STP_ERR    out  one-cycle pulse, stop bit sampled low on the frame just ended
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low; configuration is latched here
// START  | checking the start bit; a high majority means a glitch, so abort
// DATA   | shifting in data bits, LSB first
// PARITY | checking the parity bit against the received data
// STOP   | checking the stop bit in mid-bit, reporting, then back to IDLE
module uart_rx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            PRESCALE,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic                  rx_m, rx_s;
  logic [5:0]            edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic [2:0]            smp;
  logic [5:0]            prescale_q;
  logic                  par_en_q, par_typ_q;
  logic                  par_fail;

  logic [5:0] half;
  logic       at_s0, at_s1, at_s2, at_dec, at_last;
  logic       maj;
  logic       valid_nxt, par_err_nxt, stp_err_nxt;

  assign half    = {1'b0, prescale_q[5:1]};
  assign at_s0   = (edge_cnt == half - 6'd1);
  assign at_s1   = (edge_cnt == half);
  assign at_s2   = (edge_cnt == half + 6'd1);
  assign at_dec  = (edge_cnt == half + 6'd2);
  assign at_last = (edge_cnt == prescale_q - 6'd1);
  assign maj     = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    valid_nxt   = 1'b0;
    par_err_nxt = 1'b0;
    stp_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (at_dec && maj)  state_nxt = IDLE;
        else if (at_last)   state_nxt = DATA;
      end
      DATA: begin
        if (at_last && bit_cnt == LAST_BIT)
          state_nxt = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (at_last) state_nxt = STOP;
      end
      STOP: begin
        // Leaving mid-stop-bit leaves room to catch a start edge that
        // comes straight after this frame.
        if (at_dec) begin
          state_nxt   = IDLE;
          valid_nxt   = maj & ~par_fail;
          par_err_nxt = par_fail;
          stp_err_nxt = ~maj;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      smp        <= '0;
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_fail   <= 1'b0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      rx_m       <= RX_IN;
      rx_s       <= rx_m;
      DATA_VALID <= valid_nxt;
      PAR_ERR    <= par_err_nxt;
      STP_ERR    <= stp_err_nxt;
      if (valid_nxt) P_DATA <= shift;

      if (state == IDLE) begin
        // The detect cycle counts as edge 0 of the start bit.
        edge_cnt   <= rx_s ? 6'd0 : 6'd1;
        bit_cnt    <= '0;
        par_fail   <= 1'b0;
        prescale_q <= PRESCALE;
        par_en_q   <= PAR_EN;
        par_typ_q  <= PAR_TYP;
      end else begin
        if (state_nxt == IDLE || at_last) edge_cnt <= '0;
        else                              edge_cnt <= edge_cnt + 6'd1;

        if (at_s0) smp[0] <= rx_s;
        if (at_s1) smp[1] <= rx_s;
        if (at_s2) smp[2] <= rx_s;

        if (state == DATA && at_dec)
          shift <= {maj, shift[DATA_WIDTH-1:1]};
        if (state == DATA && at_last && bit_cnt != LAST_BIT)
          bit_cnt <= bit_cnt + 1'b1;

        // The expected parity bit is the XOR of the data, inverted for odd parity.
        if (state == PARITY && at_dec)
          par_fail <= (maj != ((^shift) ^ par_typ_q));
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
module tb_uart_rx_frame;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] PRESCALE;
  logic [7:0] P_DATA;
  logic       DATA_VALID, PAR_ERR, STP_ERR;

  uart_rx_frame #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .PRESCALE(PRESCALE), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [5:0] p;
    logic       pen;
    logic       ptyp;
    logic [7:0] data;
    logic       pbit;
    logic       sbit;
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] exp_data;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_strobe = 1'b0;
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (RST === 1'b1) begin
      if (prev_strobe)
        chk("strobe_one_cycle", {29'd0, DATA_VALID, PAR_ERR, STP_ERR}, 32'd0);
      else if (DATA_VALID || PAR_ERR || STP_ERR) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got dv=%b pe=%b se=%b, expected no strobe",
                   DATA_VALID, PAR_ERR, STP_ERR);
        end else begin
          e = sb.pop_front();
          chk("data_valid", {31'd0, DATA_VALID}, {31'd0, e.dv});
          chk("par_err",    {31'd0, PAR_ERR},    {31'd0, e.pe});
          chk("stp_err",    {31'd0, STP_ERR},    {31'd0, e.se});
          chk("p_data",     {24'd0, P_DATA},     {24'd0, e.data});
        end
      end
      prev_strobe = DATA_VALID | PAR_ERR | STP_ERR;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  task automatic send_bit(input logic b, input logic [5:0] p);
    RX_IN = b;
    repeat (int'(p)) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [5:0] p, input logic [7:0] d, input logic pen,
                            input logic pbit, input logic sbit);
    send_bit(1'b0, p);
    for (int i = 0; i < 8; i++) send_bit(d[i], p);
    if (pen) send_bit(pbit, p);
    send_bit(sbit, p);
    RX_IN = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (20) @(negedge CLK);
  endtask

  task automatic expect_frame(input logic dv, input logic pe, input logic se, input logic [7:0] d);
    exp_t e;
    e.dv = dv; e.pe = pe; e.se = se; e.data = d;
    sb.push_back(e);
  endtask

  vec_t vecs[9];

  initial begin
    logic [7:0] w;
    vecs[0] = '{6'd8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{6'd16, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[2] = '{6'd8,  1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[3] = '{6'd8,  1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h55};
    vecs[4] = '{6'd16, 1'b1, 1'b1, 8'h81, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h81};
    vecs[5] = '{6'd32, 1'b1, 1'b0, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h81};
    vecs[6] = '{6'd16, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[7] = '{6'd32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF};
    vecs[8] = '{6'd8,  1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01};

    RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; PRESCALE = 6'd8;

    // Reset held with the line toggling: outputs must stay 0.
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      RX_IN = ~RX_IN;
      @(negedge CLK);
      chk("reset_p_data", {24'd0, P_DATA}, 32'd0);
      chk("reset_dv",     {31'd0, DATA_VALID}, 32'd0);
      chk("reset_pe",     {31'd0, PAR_ERR}, 32'd0);
      chk("reset_se",     {31'd0, STP_ERR}, 32'd0);
    end
    RX_IN = 1'b1;
    @(negedge CLK);
    RST = 1'b1;
    repeat (10) @(negedge CLK);

    // Table-driven frames.
    for (int i = 0; i < 9; i++) begin
      PRESCALE = vecs[i].p;
      PAR_EN   = vecs[i].pen;
      PAR_TYP  = vecs[i].ptyp;
      @(negedge CLK);
      expect_frame(vecs[i].dv, vecs[i].pe, vecs[i].se, vecs[i].exp_data);
      send_frame(vecs[i].p, vecs[i].data, vecs[i].pen, vecs[i].pbit, vecs[i].sbit);
      drain();
    end
    last_good = 8'h01;

    // Short low pulse: start check must abort silently, then a good frame.
    PRESCALE = 6'd16; PAR_EN = 1'b0;
    @(negedge CLK);
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (60) @(negedge CLK);
    expect_frame(1'b1, 1'b0, 1'b0, 8'hFF);
    send_frame(6'd16, 8'hFF, 1'b0, 1'b0, 1'b1);
    drain();
    last_good = 8'hFF;

    // Break: line low for exactly one frame length -> single STP_ERR.
    PRESCALE = 6'd8; PAR_EN = 1'b0;
    @(negedge CLK);
    expect_frame(1'b0, 1'b0, 1'b1, last_good);
    RX_IN = 1'b0;
    repeat (80) @(negedge CLK);
    RX_IN = 1'b1;
    drain();
    expect_frame(1'b1, 1'b0, 1'b0, 8'h6B);
    send_frame(6'd8, 8'h6B, 1'b0, 1'b0, 1'b1);
    drain();
    last_good = 8'h6B;

    // Loopback: four back-to-back odd-parity frames at P=32.
    PRESCALE = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      w = 8'($urandom_range(0, 255));
      expect_frame(1'b1, 1'b0, 1'b0, w);
      send_frame(6'd32, w, 1'b1, ~(^w), 1'b1);
      last_good = w;
    end
    drain();

    // Reset in the middle of a frame: no strobe, P_DATA cleared.
    w = 8'($urandom_range(0, 255));
    send_bit(1'b0, 6'd32);
    for (int i = 0; i < 3; i++) send_bit(w[i], 6'd32);
    RST = 1'b0;
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (400) @(negedge CLK);
    chk("p_data_after_reset", {24'd0, P_DATA}, 32'd0);
    expect_frame(1'b1, 1'b0, 1'b0, 8'hC3);
    send_frame(6'd32, 8'hC3, 1'b1, ~(^8'hC3), 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
